// File: rtl/rtc_pkg.sv
// Shared types and helpers for the always-on RTC: BCD time-of-day layout and digit increment.
package rtc_pkg;

   typedef struct packed {
      logic [5:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
   } bcd_time_t;

   localparam logic [7:0] BCD_SEC_MAX = 8'h59;
   localparam logic [5:0] BCD_HR_MAX  = 6'h23;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_e;

   // Returns {carry, next}. Carry only at the field maximum; any digit >= 9 rolls to 0
   // so corrupted loads keep advancing instead of sticking.
   function automatic logic [8:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
      logic [3:0] lo;
      logic [3:0] hi;
      lo = val[3:0];
      hi = val[7:4];
      if (val == max) return 9'h100;
      if (lo >= 4'd9) begin
         lo = 4'd0;
         hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
      end else begin
         lo = lo + 4'd1;
      end
      return {1'b0, hi, lo};
   endfunction

endpackage

// File: rtl/rtc_timer_chan.sv
// One RTC timer channel: counts clk_i or seconds ticks up to a target, one-shot or periodic.
//
// state    | meaning
// TMR_IDLE | stopped, value held
// TMR_RUN  | counting ticks toward target
module rtc_timer_chan
   import rtc_pkg::*;
#(
   parameter int TIMER_W = 17
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               update_i,
   input  logic               enable_i,
   input  logic               retrig_i,
   input  logic               sec_i,
   input  logic [TIMER_W-1:0] target_i,
   input  logic               sec_tick_i,
   output logic [TIMER_W-1:0] value_o,
   output logic               event_o
);

   tmr_state_e         state_q, state_d;
   logic [TIMER_W-1:0] value_q, value_d;
   logic [TIMER_W-1:0] target_q;
   logic               retrig_q;
   logic               sec_q;
   logic               pulse_q, pulse_d;
   logic               cnt_tick;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= TMR_IDLE;
         value_q  <= '0;
         target_q <= '0;
         retrig_q <= 1'b0;
         sec_q    <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         pulse_q <= pulse_d;
         if (update_i) begin
            target_q <= target_i;
            retrig_q <= retrig_i;
            sec_q    <= sec_i;
         end
      end
   end

   // A reload always takes priority over a coincident match, so no event escapes it.
   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      pulse_d  = 1'b0;
      cnt_tick = sec_q ? sec_tick_i : 1'b1;
      if (update_i) begin
         value_d = '0;
         state_d = enable_i ? TMR_RUN : TMR_IDLE;
      end else if (state_q == TMR_RUN && cnt_tick) begin
         if (value_q == target_q) begin
            pulse_d = 1'b1;
            value_d = '0;
            if (!retrig_q) state_d = TMR_IDLE;
         end else begin
            value_d = value_q + TIMER_W'(1);
         end
      end
   end

   assign value_o = value_q;
   assign event_o = pulse_q;

endmodule

// File: rtl/rtc_clock_multi.sv
// Always-on RTC: prescaled BCD time-of-day, masked alarm, NUM_TIMERS timer channels and
// sticky event flags for the register wrapper.
module rtc_clock_multi
   import rtc_pkg::*;
#(
   parameter int PRESC_W    = 15,
   parameter int INIT_W     = 10,
   parameter int NUM_TIMERS = 4,
   parameter int TIMER_W    = 17
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          clock_update_i,
   input  logic [21:0]                   clock_i,
   input  logic [INIT_W-1:0]             init_sec_cnt_i,
   output logic [21:0]                   clock_o,
   input  logic                          alarm_update_i,
   input  logic                          alarm_enable_i,
   input  logic [2:0]                    alarm_mask_i,
   input  logic [21:0]                   alarm_clock_i,
   output logic [21:0]                   alarm_clock_o,
   input  logic [NUM_TIMERS-1:0]         timer_update_i,
   input  logic                          timer_enable_i,
   input  logic                          timer_retrig_i,
   input  logic                          timer_sec_i,
   input  logic [TIMER_W-1:0]            timer_target_i,
   output logic [NUM_TIMERS*TIMER_W-1:0] timer_value_o,
   output logic [NUM_TIMERS:0]           event_flags_o,
   input  logic [NUM_TIMERS:0]           event_clr_i,
   output logic                          event_o,
   output logic                          update_day_o
);

   logic [PRESC_W-1:0]  presc_q;
   logic                sec_tick;
   bcd_time_t           time_q;
   logic                day_q;
   logic [8:0]          ss_n, mm_n;
   logic [5:0]          hh_n;
   bcd_time_t           alarm_q;
   logic [2:0]          alarm_mask_q;
   logic                alarm_en_q, match_q, alarm_match, alarm_evt;
   logic [NUM_TIMERS-1:0] tmr_evt;
   logic [NUM_TIMERS:0] evt_vec, flags_q;

   // A reload restarts the second phase, so the tick is masked in that cycle.
   assign sec_tick = (presc_q == '1) && !clock_update_i;

   always_comb begin
      ss_n = bcd_inc(time_q.ss, BCD_SEC_MAX);
      mm_n = bcd_inc(time_q.mm, BCD_SEC_MAX);
      hh_n = 6'(bcd_inc({2'b00, time_q.hh}, {2'b00, BCD_HR_MAX}));
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         presc_q <= '0;
         time_q  <= '0;
         day_q   <= 1'b0;
      end else begin
         day_q <= 1'b0;
         if (clock_update_i) begin
            presc_q <= PRESC_W'(init_sec_cnt_i) << (PRESC_W - INIT_W);
            time_q  <= clock_i;
         end else begin
            presc_q <= presc_q + PRESC_W'(1);
            if (sec_tick) begin
               time_q.ss <= ss_n[7:0];
               if (ss_n[8]) begin
                  time_q.mm <= mm_n[7:0];
                  if (mm_n[8]) begin
                     time_q.hh <= hh_n;
                     day_q     <= (time_q.hh == BCD_HR_MAX);
                  end
               end
            end
         end
      end
   end

   assign alarm_match = (alarm_mask_q[2] || time_q.hh == alarm_q.hh) &&
                        (alarm_mask_q[1] || time_q.mm == alarm_q.mm) &&
                        (alarm_mask_q[0] || time_q.ss == alarm_q.ss);
   assign alarm_evt   = alarm_en_q && alarm_match && !match_q && !alarm_update_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         alarm_q      <= '0;
         alarm_mask_q <= '0;
         alarm_en_q   <= 1'b0;
         match_q      <= 1'b0;
      end else begin
         match_q <= alarm_match;
         if (alarm_update_i) begin
            alarm_q      <= alarm_clock_i;
            alarm_mask_q <= alarm_mask_i;
            alarm_en_q   <= alarm_enable_i;
         end else if (alarm_evt) begin
            alarm_en_q <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
      rtc_timer_chan #(.TIMER_W(TIMER_W)) u_chan (
         .clk_i      (clk_i),
         .rstn_i     (rstn_i),
         .update_i   (timer_update_i[i]),
         .enable_i   (timer_enable_i),
         .retrig_i   (timer_retrig_i),
         .sec_i      (timer_sec_i),
         .target_i   (timer_target_i),
         .sec_tick_i (sec_tick),
         .value_o    (timer_value_o[i*TIMER_W +: TIMER_W]),
         .event_o    (tmr_evt[i])
      );
   end

   assign evt_vec = {tmr_evt, alarm_evt};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) flags_q <= '0;
      else         flags_q <= (flags_q & ~event_clr_i) | evt_vec;
   end

   assign clock_o       = time_q;
   assign alarm_clock_o = alarm_q;
   assign update_day_o  = day_q;
   assign event_flags_o = flags_q;
   assign event_o       = |evt_vec;

endmodule

// File: tb/tb_rtc_clock_multi.sv
// Bench for rtc_clock_multi: BCD rollover table, directed alarm/timer corners, then random
// traffic against a seconds-of-day / tick-count reference model.
module tb_rtc_clock_multi;

   localparam int PRESC_W    = 6;
   localparam int INIT_W     = 4;
   localparam int NUM_TIMERS = 4;
   localparam int TIMER_W    = 17;
   localparam int NF         = NUM_TIMERS + 1;

   logic                          clk_i = 1'b0;
   logic                          rstn_i;
   logic                          clock_update_i;
   logic [21:0]                   clock_i;
   logic [INIT_W-1:0]             init_sec_cnt_i;
   logic [21:0]                   clock_o;
   logic                          alarm_update_i;
   logic                          alarm_enable_i;
   logic [2:0]                    alarm_mask_i;
   logic [21:0]                   alarm_clock_i;
   logic [21:0]                   alarm_clock_o;
   logic [NUM_TIMERS-1:0]         timer_update_i;
   logic                          timer_enable_i;
   logic                          timer_retrig_i;
   logic                          timer_sec_i;
   logic [TIMER_W-1:0]            timer_target_i;
   logic [NUM_TIMERS*TIMER_W-1:0] timer_value_o;
   logic [NF-1:0]                 event_flags_o;
   logic [NF-1:0]                 event_clr_i;
   logic                          event_o;
   logic                          update_day_o;

   rtc_clock_multi #(
      .PRESC_W(PRESC_W), .INIT_W(INIT_W), .NUM_TIMERS(NUM_TIMERS), .TIMER_W(TIMER_W)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .clock_update_i(clock_update_i), .clock_i(clock_i), .init_sec_cnt_i(init_sec_cnt_i),
      .clock_o(clock_o),
      .alarm_update_i(alarm_update_i), .alarm_enable_i(alarm_enable_i),
      .alarm_mask_i(alarm_mask_i), .alarm_clock_i(alarm_clock_i), .alarm_clock_o(alarm_clock_o),
      .timer_update_i(timer_update_i), .timer_enable_i(timer_enable_i),
      .timer_retrig_i(timer_retrig_i), .timer_sec_i(timer_sec_i),
      .timer_target_i(timer_target_i), .timer_value_o(timer_value_o),
      .event_flags_o(event_flags_o), .event_clr_i(event_clr_i),
      .event_o(event_o), .update_day_o(update_day_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [21:0] load;
      logic [21:0] nxt;
      logic        day;
   } tvec_t;
   tvec_t tbl[10];

   int n_vec = 0;
   int n_err = 0;

   // Reference model: time as seconds-of-day, timers as ticks counted since (re)start.
   int            m_presc, m_tod;
   bit            m_ok, m_day;
   bit            m_al_en, m_match_prev;
   logic [21:0]   m_al_time;
   logic [2:0]    m_al_mask;
   bit            m_run[NUM_TIMERS];
   int            m_cnt[NUM_TIMERS];
   int            m_tgt[NUM_TIMERS];
   bit            m_retrig[NUM_TIMERS];
   bit            m_sec[NUM_TIMERS];
   bit            m_pulse[NUM_TIMERS];
   logic [NF-1:0] m_flags;

   function automatic logic [21:0] bcd(int h, int m, int s);
      return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [21:0] tod_bcd(int t);
      return bcd(t / 3600, (t / 60) % 60, t % 60);
   endfunction

   function automatic int bcd_to_tod(logic [21:0] v);
      int h, m, s;
      if (v[19:16] > 4'd9 || v[11:8] > 4'd9 || v[3:0] > 4'd9) return -1;
      h = 10 * int'(v[21:20]) + int'(v[19:16]);
      m = 10 * int'(v[15:12]) + int'(v[11:8]);
      s = 10 * int'(v[7:4]) + int'(v[3:0]);
      if (h > 23 || m > 59 || s > 59) return -1;
      return h * 3600 + m * 60 + s;
   endfunction

   task automatic model_reset();
      m_presc = 0; m_tod = 0; m_ok = 1; m_day = 0;
      m_al_en = 0; m_match_prev = 0; m_al_time = '0; m_al_mask = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         m_run[i] = 0; m_cnt[i] = 0; m_tgt[i] = 0;
         m_retrig[i] = 0; m_sec[i] = 0; m_pulse[i] = 0;
      end
      m_flags = '0;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_strobes();
      clock_update_i = 0;
      alarm_update_i = 0;
      timer_update_i = '0;
      event_clr_i    = '0;
   endtask

   // Called just after a falling edge with inputs already driven: compare, advance model, next cycle.
   task automatic step();
      bit            tick, mnow, aevt;
      logic [NF-1:0] evec;
      logic [21:0]   cur;
      #1;
      cur  = tod_bcd(m_tod);
      mnow = m_ok && (m_al_mask[2] || cur[21:16] == m_al_time[21:16])
                  && (m_al_mask[1] || cur[15:8]  == m_al_time[15:8])
                  && (m_al_mask[0] || cur[7:0]   == m_al_time[7:0]);
      aevt = m_al_en && mnow && !m_match_prev && !alarm_update_i;
      evec[0] = aevt;
      for (int i = 0; i < NUM_TIMERS; i++) evec[i+1] = m_pulse[i];
      if (m_ok) begin
         chk("clock_o", clock_o, cur);
         chk("update_day_o", update_day_o, m_day);
      end
      chk("alarm_clock_o", alarm_clock_o, m_al_time);
      chk("event_o", event_o, |evec);
      chk("event_flags_o", event_flags_o, m_flags);
      for (int i = 0; i < NUM_TIMERS; i++)
         chk($sformatf("timer_value_o[%0d]", i), timer_value_o[i*TIMER_W +: TIMER_W],
             m_cnt[i] % (m_tgt[i] + 1));

      if (!rstn_i) begin
         model_reset();
      end else begin
         tick  = (m_presc == (1 << PRESC_W) - 1) && !clock_update_i;
         m_day = tick && m_ok && m_tod == 86399;
         if (clock_update_i) begin
            m_presc = int'(init_sec_cnt_i) << (PRESC_W - INIT_W);
            m_tod   = bcd_to_tod(clock_i);
            m_ok    = (m_tod >= 0);
            if (!m_ok) m_tod = 0;
         end else begin
            m_presc = (m_presc + 1) % (1 << PRESC_W);
            if (tick && m_ok) m_tod = (m_tod + 1) % 86400;
         end
         m_match_prev = mnow;
         if (alarm_update_i) begin
            m_al_en = alarm_enable_i; m_al_time = alarm_clock_i; m_al_mask = alarm_mask_i;
         end else if (aevt) begin
            m_al_en = 0;
         end
         for (int i = 0; i < NUM_TIMERS; i++) begin
            m_pulse[i] = 0;
            if (timer_update_i[i]) begin
               m_run[i] = timer_enable_i; m_cnt[i] = 0; m_tgt[i] = int'(timer_target_i);
               m_retrig[i] = timer_retrig_i; m_sec[i] = timer_sec_i;
            end else if (m_run[i] && (!m_sec[i] || tick)) begin
               m_cnt[i]++;
               if (m_cnt[i] % (m_tgt[i] + 1) == 0) begin
                  m_pulse[i] = 1;
                  if (!m_retrig[i]) m_run[i] = 0;
               end
            end
         end
         m_flags = (m_flags & ~event_clr_i) | evec;
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cnt, first;
      bit found;
      tbl[0] = '{bcd(0, 0, 0),   bcd(0, 0, 1),   1'b0};
      tbl[1] = '{bcd(0, 0, 9),   bcd(0, 0, 10),  1'b0};
      tbl[2] = '{bcd(0, 0, 59),  bcd(0, 1, 0),   1'b0};
      tbl[3] = '{22'h00007A,     22'h000080,     1'b0};
      tbl[4] = '{bcd(0, 59, 59), bcd(1, 0, 0),   1'b0};
      tbl[5] = '{bcd(9, 59, 59), bcd(10, 0, 0),  1'b0};
      tbl[6] = '{bcd(12, 34, 56), bcd(12, 34, 57), 1'b0};
      tbl[7] = '{bcd(19, 59, 59), bcd(20, 0, 0), 1'b0};
      tbl[8] = '{bcd(23, 59, 58), bcd(23, 59, 59), 1'b0};
      tbl[9] = '{bcd(23, 59, 59), bcd(0, 0, 0),  1'b1};

      rstn_i = 0;
      clear_strobes();
      clock_i = '0; init_sec_cnt_i = '0;
      alarm_enable_i = 0; alarm_mask_i = '0; alarm_clock_i = '0;
      timer_enable_i = 0; timer_retrig_i = 0; timer_sec_i = 0; timer_target_i = '0;
      model_reset();
      @(negedge clk_i);
      step();
      step();
      rstn_i = 1;
      step();

      // BCD rollover table: load with prescaler 4 cycles short of a tick.
      for (int k = 0; k < 10; k++) begin
         clock_update_i = 1; clock_i = tbl[k].load; init_sec_cnt_i = '1;
         step();
         clear_strobes();
         repeat (4) step();
         #1;
         chk($sformatf("tbl[%0d].clock", k), clock_o, tbl[k].nxt);
         chk($sformatf("tbl[%0d].day", k), update_day_o, tbl[k].day);
         step();
         chk($sformatf("tbl[%0d].day_drop", k), update_day_o, 1'b0);
      end

      // Alarm with hours masked: exactly one event when 10:00:59 rolls to 10:01:00.
      clock_update_i = 1; clock_i = bcd(10, 0, 59); init_sec_cnt_i = '1;
      step();
      clear_strobes();
      alarm_update_i = 1; alarm_enable_i = 1; alarm_mask_i = 3'b100; alarm_clock_i = bcd(0, 1, 0);
      step();
      clear_strobes();
      cnt = 0;
      repeat (60) begin
         #1;
         if (event_o === 1'b1) cnt++;
         step();
      end
      chk("alarm_event_count", cnt, 1);
      chk("alarm_flag", event_flags_o[0], 1'b1);
      event_clr_i = 5'b00001;
      step();
      clear_strobes();

      // Timer 0: clk mode, target 9, periodic -> event every 10 cycles.
      timer_update_i = 4'b0001; timer_enable_i = 1; timer_retrig_i = 1;
      timer_sec_i = 0; timer_target_i = 17'd9;
      step();
      clear_strobes();
      cnt = 0; first = -1;
      for (int k = 0; k < 35; k++) begin
         #1;
         if (event_o === 1'b1) begin
            if (first < 0) first = k;
            cnt++;
         end
         step();
      end
      chk("t0_first_event", first, 10);
      chk("t0_event_count", cnt, 3);
      chk("t0_flag", event_flags_o[1], 1'b1);

      // Timer 1: one-shot target 3 -> fires once, value parks at 0.
      timer_update_i = 4'b0010; timer_enable_i = 1; timer_retrig_i = 0; timer_target_i = 17'd3;
      step();
      clear_strobes();
      repeat (15) step();
      chk("t1_flag", event_flags_o[2], 1'b1);
      chk("t1_value", timer_value_o[TIMER_W +: TIMER_W], 0);
      event_clr_i = 5'b00100;
      step();
      clear_strobes();
      repeat (15) step();
      chk("t1_no_repeat", event_flags_o[2], 1'b0);

      // Clear of flag 1 coinciding with a timer 0 event: the set wins.
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (m_pulse[0]) found = 1;
         else step();
      end
      chk("t0_pulse_found", found, 1'b1);
      event_clr_i = 5'b00010;
      step();
      clear_strobes();
      #1;
      chk("flag1_set_wins", event_flags_o[1], 1'b1);
      event_clr_i = 5'b00010;
      step();
      clear_strobes();
      #1;
      chk("flag1_cleared", event_flags_o[1], 1'b0);

      // Timer 2 reloaded in its match cycle: no event, value restarts at 0.
      timer_update_i = 4'b0100; timer_enable_i = 1; timer_retrig_i = 1; timer_target_i = 17'd4;
      step();
      clear_strobes();
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (m_run[2] && (m_cnt[2] % 5) == 4) found = 1;
         else step();
      end
      chk("t2_match_found", found, 1'b1);
      timer_update_i = 4'b0100;
      step();
      clear_strobes();
      #1;
      chk("t2_value_after_update", timer_value_o[2*TIMER_W +: TIMER_W], 0);
      step();
      chk("t2_no_event_flag", event_flags_o[3], 1'b0);
      timer_update_i = 4'b0101; timer_enable_i = 0;
      step();
      clear_strobes();

      // Timer 3 in seconds mode, target 2; a clock reload moves the third tick earlier.
      clock_update_i = 1; clock_i = bcd(12, 0, 0); init_sec_cnt_i = '1;
      timer_update_i = 4'b1000; timer_enable_i = 1; timer_retrig_i = 0;
      timer_sec_i = 1; timer_target_i = 17'd2;
      step();
      clear_strobes();
      timer_sec_i = 0;
      repeat (99) step();
      chk("t3_value_two_ticks", timer_value_o[3*TIMER_W +: TIMER_W], 2);
      clock_update_i = 1; clock_i = bcd(12, 0, 0); init_sec_cnt_i = '1;
      step();
      clear_strobes();
      repeat (3) step();
      #1;
      chk("t3_no_event_before_tick", event_o, 1'b0);
      step();
      #1;
      chk("t3_event_third_tick", event_o, 1'b1);
      step();
      #1;
      chk("t3_flag", event_flags_o[4], 1'b1);
      step();

      // Asynchronous reset in the middle of a count.
      timer_update_i = 4'b0001; timer_enable_i = 1; timer_retrig_i = 1; timer_target_i = 17'd50;
      step();
      clear_strobes();
      repeat (20) step();
      #2 rstn_i = 0;
      #1;
      chk("rst_clock", clock_o, 0);
      chk("rst_t0_value", timer_value_o[TIMER_W-1:0], 0);
      chk("rst_flags", event_flags_o, 0);
      chk("rst_alarm_clock", alarm_clock_o, 0);
      model_reset();
      step();
      rstn_i = 1;
      step();

      // Random traffic against the model.
      repeat (3000) begin
         clear_strobes();
         if ($urandom_range(0, 63) == 0) begin
            clock_update_i = 1;
            clock_i = bcd(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                          int'($urandom_range(0, 59)));
            init_sec_cnt_i = INIT_W'($urandom);
         end
         if ($urandom_range(0, 99) == 0) begin
            alarm_update_i = 1;
            alarm_enable_i = 1'($urandom);
            alarm_mask_i   = 3'($urandom);
            alarm_clock_i  = tod_bcd((m_tod + int'($urandom_range(0, 3))) % 86400);
         end
         if ($urandom_range(0, 15) == 0) begin
            timer_update_i = NUM_TIMERS'($urandom);
            timer_enable_i = ($urandom_range(0, 3) != 0);
            timer_retrig_i = 1'($urandom);
            timer_sec_i    = ($urandom_range(0, 3) == 0);
            timer_target_i = TIMER_W'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 3) == 0) event_clr_i = NF'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
